// File: rtl/seq_display.sv
// Plays back a latched digit sequence to the player display: each digit is lit for
// ON_CYCLES cycles and then blanked for OFF_CYCLES, with a one-cycle done pulse at the end.
module seq_display #(
    parameter int ON_CYCLES  = 25000000,
    parameter int OFF_CYCLES = 12500000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        newSequence,
    input  logic [19:0] Sequence,
    input  logic [2:0]  LVL,
    output logic [3:0]  digit_out,
    output logic        digit_valid,
    output logic        display_done,
    output logic        busy
);

    localparam int MAX_CYCLES = (ON_CYCLES > OFF_CYCLES) ? ON_CYCLES : OFF_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
    localparam logic [CNT_W-1:0] ON_LOAD  = CNT_W'(ON_CYCLES - 1);
    localparam logic [CNT_W-1:0] OFF_LOAD = CNT_W'(OFF_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {IDLE, SHOW, GAP, DONE} state_t;

    state_t            state_q, state_d;
    logic [19:0]       seq_q, seq_d;
    logic [2:0]        lvl_q, lvl_d;
    logic [2:0]        idx_q, idx_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [3:0]        digit_out_q, digit_out_d;
    logic              digit_valid_q, digit_valid_d;
    logic              display_done_q, display_done_d;
    logic              busy_q, busy_d;

    function automatic logic [2:0] digit_count(input logic [2:0] lvl);
        if (lvl == 3'd0)
            return 3'd1;
        else if (lvl > 3'd5)
            return 3'd5;
        else
            return lvl;
    endfunction

    function automatic logic [3:0] digit_at(input logic [19:0] seq, input logic [2:0] idx);
        case (idx)
            3'd0:    return seq[19:16];
            3'd1:    return seq[15:12];
            3'd2:    return seq[11:8];
            3'd3:    return seq[7:4];
            default: return seq[3:0];
        endcase
    endfunction

    always_comb begin
        state_d = state_q;
        seq_d   = seq_q;
        lvl_d   = lvl_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE: begin
                if (newSequence) begin
                    seq_d   = Sequence;
                    lvl_d   = LVL;
                    idx_d   = 3'd0;
                    cnt_d   = ON_LOAD;
                    state_d = SHOW;
                end
            end
            SHOW: begin
                if (cnt_q == '0) begin
                    cnt_d   = OFF_LOAD;
                    state_d = GAP;
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            GAP: begin
                if (cnt_q == '0) begin
                    if (idx_q == digit_count(lvl_q) - 3'd1) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + 3'd1;
                        cnt_d   = ON_LOAD;
                        state_d = SHOW;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_ONE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are decoded from the next state so they are registered yet line up with it.
        digit_valid_d  = (state_d == SHOW);
        digit_out_d    = digit_valid_d ? digit_at(seq_d, idx_d) : 4'd0;
        display_done_d = (state_d == DONE);
        busy_d         = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= IDLE;
            seq_q          <= '0;
            lvl_q          <= '0;
            idx_q          <= '0;
            cnt_q          <= '0;
            digit_out_q    <= '0;
            digit_valid_q  <= 1'b0;
            display_done_q <= 1'b0;
            busy_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            seq_q          <= seq_d;
            lvl_q          <= lvl_d;
            idx_q          <= idx_d;
            cnt_q          <= cnt_d;
            digit_out_q    <= digit_out_d;
            digit_valid_q  <= digit_valid_d;
            display_done_q <= display_done_d;
            busy_q         <= busy_d;
        end
    end

    assign digit_out    = digit_out_q;
    assign digit_valid  = digit_valid_q;
    assign display_done = display_done_q;
    assign busy         = busy_q;

endmodule

// File: tb/tb_seq_display.sv
// Scoreboard bench for seq_display: accepted starts enqueue the expected lit digits and
// the done pulse with their absolute cycles; a monitor pops and compares on every output.
module tb_seq_display;

    localparam int ON  = 3;
    localparam int OFF = 2;
    localparam int PER = ON + OFF;

    logic        clk = 1'b0;
    logic        rst;
    logic        newSequence;
    logic [19:0] Sequence;
    logic [2:0]  LVL;
    logic [3:0]  digit_out;
    logic        digit_valid;
    logic        display_done;
    logic        busy;

    seq_display #(.ON_CYCLES(ON), .OFF_CYCLES(OFF)) dut (
        .clk          (clk),
        .rst          (rst),
        .newSequence  (newSequence),
        .Sequence     (Sequence),
        .LVL          (LVL),
        .digit_out    (digit_out),
        .digit_valid  (digit_valid),
        .display_done (display_done),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int       cyc;
        bit       is_done;
        logic [3:0] val;
    } ev_t;

    ev_t sb[$];
    int  cyc     = 0;
    int  m_start = 0;
    int  m_end   = -1;
    int  checks  = 0;
    int  errors  = 0;
    bit  mon_en  = 1'b0;
    ev_t mev;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, exp);
        end
    endtask

    // Reference: playback of n digits occupies cycles start+1 .. start+n*PER+1.
    task automatic step(input bit ns, input logic [19:0] s, input logic [2:0] l, input bit r);
        int n;
        @(posedge clk);
        #1;
        newSequence = ns;
        Sequence    = s;
        LVL         = l;
        rst         = r;
        if (r) begin
            while (sb.size() > 0 && sb[$].cyc > cyc) void'(sb.pop_back());
            if (m_end > cyc) m_end = cyc;
        end else if (ns && cyc > m_end) begin
            n = (l == 0) ? 1 : ((l > 5) ? 5 : int'(l));
            m_start = cyc;
            m_end   = cyc + n * PER + 1;
            for (int k = 0; k < n; k++) begin
                for (int j = 0; j < ON; j++) begin
                    ev_t e;
                    e.cyc     = cyc + 1 + k * PER + j;
                    e.is_done = 1'b0;
                    e.val     = 4'((s >> (16 - 4 * k)) & 20'hF);
                    sb.push_back(e);
                end
            end
            begin
                ev_t d;
                d.cyc     = m_end;
                d.is_done = 1'b1;
                d.val     = 4'd0;
                sb.push_back(d);
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_en) begin
            chk("busy", int'(busy), int'(cyc > m_start && cyc <= m_end));
            if (!digit_valid) chk("digit_out_blank", int'(digit_out), 0);
            while (sb.size() > 0 && sb[0].cyc < cyc) begin
                mev = sb.pop_front();
                chk("missed_event_cycle", cyc, mev.cyc);
            end
            if (digit_valid || display_done) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL spurious_output at cycle %0d: valid=%0d done=%0d, expected none",
                             cyc, digit_valid, display_done);
                end else begin
                    mev = sb.pop_front();
                    chk("event_cycle", cyc, mev.cyc);
                    chk("digit_valid", int'(digit_valid), int'(!mev.is_done));
                    chk("display_done", int'(display_done), int'(mev.is_done));
                    if (!mev.is_done) chk("digit_value", int'(digit_out), int'(mev.val));
                end
            end
        end
    end

    initial begin
        rst         = 1'b1;
        newSequence = 1'b0;
        Sequence    = '0;
        LVL         = '0;
        step(0, 20'h0, 3'd0, 1);
        step(0, 20'h0, 3'd0, 1);
        mon_en = 1'b1;
        step(0, 20'h0, 3'd0, 0);
        @(negedge clk);
        chk("reset_digit_out", int'(digit_out), 0);
        chk("reset_digit_valid", int'(digit_valid), 0);
        chk("reset_display_done", int'(display_done), 0);
        chk("reset_busy", int'(busy), 0);

        // Basic three-digit playback with an ignored second start at cycle 5.
        for (int i = 0; i < 20; i++)
            step(i == 0 || i == 5, (i == 5) ? 20'hFFFFF : 20'h12345, 3'd3, 0);
        // Reset mid-playback, then a fresh two-digit start.
        for (int i = 0; i < 25; i++)
            step(i == 0 || i == 10, (i >= 10) ? 20'h98765 : 20'h12345,
                 (i >= 10) ? 3'd2 : 3'd3, i == 7);
        // Sequence changes after the latch cycle must not leak into the display.
        for (int i = 0; i < 14; i++)
            step(i == 0, (i >= 2) ? 20'h00000 : 20'h12345, 3'd2, 0);
        // Level extremes.
        for (int i = 0; i < 10; i++) step(i == 0, 20'hA0000, 3'd0, 0);
        for (int i = 0; i < 30; i++) step(i == 0, 20'hABCDE, (i == 0) ? 3'd7 : 3'd1, 0);
        // Start and reset together in IDLE.
        step(1, 20'h12345, 3'd3, 1);
        for (int i = 0; i < 5; i++) step(0, 20'h12345, 3'd3, 0);

        for (int i = 0; i < 3000; i++)
            step($urandom_range(0, 7) == 0, 20'($urandom), 3'($urandom_range(0, 7)),
                 $urandom_range(0, 79) == 0);

        for (int i = 0; i < 40; i++) step(0, 20'h0, 3'd0, 0);
        @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seq_display.md
SEQ_DISPLAY -- requirements
Module: seq_display

Interface
REQ-001 Parameter ON_CYCLES, default 25000000, clock cycles each digit is shown; SHALL be >= 1.
REQ-002 Parameter OFF_CYCLES, default 12500000, blank cycles after each digit; SHALL be >= 1.
REQ-003 clk  input  1  single system clock; all state SHALL change on its rising edge only.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 newSequence  input  1  one-cycle start strobe from the sequence generator.
REQ-006 Sequence  input  20  five 4-bit digits; digit 0 = Sequence[19:16], digit 4 = Sequence[3:0].
REQ-007 LVL  input  3  current level; selects how many digits are shown.
REQ-008 digit_out  output  4  digit currently presented to the player display.
REQ-009 digit_valid  output  1  high while digit_out holds a digit to be lit.
REQ-010 display_done  output  1  one-cycle pulse when the whole playback has finished; feeds the verifier.
REQ-011 busy  output  1  high while a playback is in progress, including the done cycle.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, SHOW, GAP, DONE.
REQ-013 In IDLE, a cycle with newSequence=1 SHALL latch Sequence and LVL into internal registers, clear digit index idx to 0, load the phase counter, and enter SHOW.
REQ-014 Digit count n SHALL be derived from the latched LVL: 0 -> 1, 1..5 -> LVL, 6..7 -> 5.
REQ-015 SHOW SHALL last exactly ON_CYCLES cycles, with digit_valid=1 and digit_out = latched digit idx.
REQ-016 GAP SHALL last exactly OFF_CYCLES cycles, with digit_valid=0 and digit_out=0.
REQ-017 At the end of GAP: if idx = n-1, enter DONE; otherwise increment idx and enter SHOW.
REQ-018 DONE SHALL last one cycle with display_done=1, then return to IDLE.
REQ-019 Latency: with newSequence sampled in cycle 0, digit 0 SHALL be valid from cycle 1, and display_done SHALL be high in cycle n*(ON_CYCLES+OFF_CYCLES)+1 only.
REQ-020 busy SHALL be 1 in SHOW, GAP and DONE, and 0 in IDLE.
REQ-021 newSequence asserted outside IDLE (including the DONE cycle) SHALL be ignored; the running playback SHALL be neither restarted nor altered.
REQ-022 Changes on Sequence or LVL after the latch cycle SHALL have no effect until the next accepted start.
REQ-023 The phase counter SHALL be wide enough for max(ON_CYCLES, OFF_CYCLES) and SHALL never wrap during a phase.
REQ-024 display_done SHALL never be high for more than one consecutive cycle, and SHALL be high exactly once per accepted start.
REQ-025 All outputs SHALL be registered, with no combinational path from any input to any output.

Reset
REQ-026 rst=1 SHALL force, on the next edge: state IDLE, idx 0, counter 0, latched registers 0, digit_out 0, digit_valid 0, display_done 0, busy 0.
REQ-027 rst SHALL take priority over newSequence in the same cycle; no playback starts.
REQ-028 rst asserted mid-playback SHALL abort it with no display_done pulse; the next newSequence after rst deasserts SHALL start a fresh playback.

Verification (ON_CYCLES=3, OFF_CYCLES=2)
REQ-029 Sequence=20'h12345, LVL=3, newSequence at cycle 0 -> digit_out 1/2/3 valid in cycles 1-3, 6-8 and 11-13; digit_valid=0 in cycles 4-5, 9-10 and 14-15; display_done=1 in cycle 16 only; busy=1 in cycles 1-16.
REQ-030 LVL=0, Sequence=20'hA0000 -> one digit A in cycles 1-3, display_done in cycle 6; LVL=7 -> five digits shown, display_done in cycle 26.
REQ-031 Second newSequence at cycle 5 carrying Sequence=20'hFFFFF during the REQ-029 playback -> output identical to REQ-029, with a single display_done pulse.
REQ-032 rst at cycle 7 of the REQ-029 playback -> all outputs 0 from cycle 8, no display_done; a new start at cycle 10 with 20'h98765, LVL=2 -> digits 9 then 8, display_done in cycle 21.
REQ-033 Sequence changed to 20'h00000 at cycle 2 after a start with 20'h12345, LVL=2 -> digits 1 and 2 still shown.
REQ-034 newSequence and rst both high in the same IDLE cycle -> busy stays 0 and no digit_valid follows.
